cookie_rotator: RTL and testbench

Multi-channel, parametrised cookie generator with periodic and on-demand key rotation. It keeps a current and a previous cookie per channel and answers single-cycle cookie validation queries. The block sits beside the RMT pipeline's timestamp source and feeds per-port/per-table cookies to the parser and deparser stages. A previous-key grace window lets in-flight packets that carry the old cookie still validate during rotation.

---
 rtl/cookie_pkg.sv | 28 ++
 rtl/cookie_rotator_if.sv | 22 ++
 rtl/cookie_check.sv | 42 ++++
 rtl/cookie_rotator.sv | 163 ++++++++++++++++
 tb/tb_cookie_rotator.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cookie_pkg.sv
// cookie_rotator shared package: base constant, FSM states, mix function.
// Optional feature macro: COOKIE_PREV_EN (previous-cookie grace window).
package cookie_pkg;

    localparam logic [95:0] COOKIE_BASE_96 = {3{32'hF1EC234D}};

    typedef enum logic {
        IDLE,
        ROTATE
    } state_t;

    // new = ((cur + (t >> len/2)) ^ t) ^ ch, all modulo 2^len
    function automatic logic [95:0] cookie_mix(
        input logic [95:0] cur,
        input logic [95:0] t,
        input logic [95:0] ch,
        input int unsigned len
    );
        logic [95:0] mask;
        logic [95:0] tm;
        logic [95:0] sum;
        mask = (len >= 96) ? '1 : ((96'd1 << len) - 96'd1);
        tm   = t & mask;
        sum  = (cur + (tm >> (len / 2))) & mask;
        return ((sum ^ tm) ^ ch) & mask;
    endfunction

endpackage

// File: rtl/cookie_rotator_if.sv
// Cookie check request/response bundle.
// Optional feature macro: COOKIE_PREV_EN (affects response meaning only).
interface cookie_rotator_if #(
    parameter int COOKIE_LEN = 32
);
    logic                  chk_vld;
    logic [3:0]            chk_ch;
    logic [COOKIE_LEN-1:0] chk_cookie;
    logic                  chk_rsp_vld;
    logic                  chk_hit;
    logic                  chk_stale;

    modport master (
        output chk_vld, chk_ch, chk_cookie,
        input  chk_rsp_vld, chk_hit, chk_stale
    );

    modport slave (
        input  chk_vld, chk_ch, chk_cookie,
        output chk_rsp_vld, chk_hit, chk_stale
    );
endinterface

// File: rtl/cookie_check.sv
// Registered cookie compare stage, one request per cycle.
// Optional feature macro: COOKIE_PREV_EN enables the previous-cookie match.
module cookie_check #(
    parameter int COOKIE_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld,
    input  logic                  ch_ok,
    input  logic [COOKIE_LEN-1:0] cookie,
    input  logic [COOKIE_LEN-1:0] cur,
    input  logic [COOKIE_LEN-1:0] prev,
    output logic                  rsp_vld,
    output logic                  hit,
    output logic                  stale
);
    logic m_cur;
    logic m_prev;

    assign m_cur = ch_ok && (cookie == cur);
`ifdef COOKIE_PREV_EN
    assign m_prev = ch_ok && (cookie == prev);
`else
    logic unused_prev;
    assign unused_prev = ^prev;
    assign m_prev = 1'b0;
`endif

    // register the response; hit/stale only meaningful with a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld <= 1'b0;
            hit     <= 1'b0;
            stale   <= 1'b0;
        end else begin
            rsp_vld <= vld;
            hit     <= vld && (m_cur || m_prev);
            stale   <= vld && m_prev && !m_cur;
        end
    end

endmodule

// File: rtl/cookie_rotator.sv
// Multi-channel cookie generator with timed/forced rotation and checks.
// Optional feature macro: COOKIE_PREV_EN keeps previous cookies per channel.
module cookie_rotator
    import cookie_pkg::*;
#(
    parameter int              COOKIE_LEN = 32,
    parameter int              NUM_CH     = 4,
    parameter int              PERIOD_W   = 32,
    parameter logic [PERIOD_W-1:0] DEF_PERIOD = 32'h8000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [95:0]                  time_stamp,
    input  logic [PERIOD_W-1:0]          cfg_period,
    input  logic                         cfg_period_vld,
    input  logic                         rot_req,
    cookie_rotator_if.slave              chk,
    output logic [NUM_CH*COOKIE_LEN-1:0] cookie_cur,
    output logic [NUM_CH*COOKIE_LEN-1:0] cookie_prev,
    output logic [15:0]                  epoch,
    output logic                         rot_busy
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    logic [COOKIE_LEN-1:0] cur [NUM_CH];
`ifdef COOKIE_PREV_EN
    logic [COOKIE_LEN-1:0] prev [NUM_CH];
`endif

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [COOKIE_LEN-1:0] ts;
    logic                  pending;
    logic [PERIOD_W-1:0]   period;
    logic [PERIOD_W-1:0]   cnt;
    logic                  tick;
    logic                  trigger;
    logic [COOKIE_LEN-1:0] mix_val;

    logic unused_ts;
    assign unused_ts = ^time_stamp;

    function automatic logic [COOKIE_LEN-1:0] rst_val(input int i);
        return COOKIE_BASE_96[COOKIE_LEN-1:0] ^ COOKIE_LEN'(i);
    endfunction

    assign tick = !cfg_period_vld && (period != '0)
                  && (cnt == period - PERIOD_W'(1));
    assign trigger = tick || rot_req;

    assign mix_val = COOKIE_LEN'(cookie_mix(96'(cur[idx]), 96'(ts),
                                            96'(idx), COOKIE_LEN));

    // rotation period counter; a config load restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= DEF_PERIOD;
            cnt    <= '0;
        end else if (cfg_period_vld) begin
            period <= cfg_period;
            cnt    <= '0;
        end else if (period == '0 || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_W'(1);
        end
    end

    // rotation FSM: walks channels one per cycle, one-deep pending retrigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            ts       <= '0;
            pending  <= 1'b0;
            epoch    <= '0;
            rot_busy <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur[i] <= rst_val(i);
`ifdef COOKIE_PREV_EN
                prev[i] <= rst_val(i);
`endif
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        ts       <= time_stamp[COOKIE_LEN-1:0];
                        idx      <= '0;
                        state    <= ROTATE;
                        rot_busy <= 1'b1;
                    end
                end
                ROTATE: begin
`ifdef COOKIE_PREV_EN
                    prev[idx] <= cur[idx];
`endif
                    cur[idx] <= mix_val;
                    if (idx == LAST) begin
                        epoch <= epoch + 16'd1;
                        idx   <= '0;
                        if (pending || trigger) begin
                            pending <= 1'b0;
                            ts      <= time_stamp[COOKIE_LEN-1:0];
                        end else begin
                            state    <= IDLE;
                            rot_busy <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                        if (trigger) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rot_busy <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign cookie_cur[g*COOKIE_LEN +: COOKIE_LEN] = cur[g];
`ifdef COOKIE_PREV_EN
        assign cookie_prev[g*COOKIE_LEN +: COOKIE_LEN] = prev[g];
`else
        assign cookie_prev[g*COOKIE_LEN +: COOKIE_LEN] = '0;
`endif
    end

    logic                  ch_ok;
    logic [IDX_W-1:0]      sel;
    logic [COOKIE_LEN-1:0] cur_sel;
    logic [COOKIE_LEN-1:0] prev_sel;

    assign ch_ok   = ({1'b0, chk.chk_ch} < 5'(NUM_CH));
    assign sel     = chk.chk_ch[IDX_W-1:0];
    assign cur_sel = ch_ok ? cur[sel] : '0;
`ifdef COOKIE_PREV_EN
    assign prev_sel = ch_ok ? prev[sel] : '0;
`else
    assign prev_sel = '0;
`endif

    cookie_check #(
        .COOKIE_LEN (COOKIE_LEN)
    ) u_check (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (chk.chk_vld),
        .ch_ok   (ch_ok),
        .cookie  (chk.chk_cookie),
        .cur     (cur_sel),
        .prev    (prev_sel),
        .rsp_vld (chk.chk_rsp_vld),
        .hit     (chk.chk_hit),
        .stale   (chk.chk_stale)
    );

endmodule

// File: tb/tb_cookie_rotator.sv
// Directed testbench for cookie_rotator (COOKIE_LEN=32, NUM_CH=4).
// Honours COOKIE_PREV_EN in its expectations.
module tb_cookie_rotator;

`ifdef COOKIE_PREV_EN
    localparam bit PREV = 1'b1;
`else
    localparam bit PREV = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'hF1EC234D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [95:0]  time_stamp;
    logic [31:0]  cfg_period;
    logic         cfg_period_vld;
    logic         rot_req;
    logic [127:0] cookie_cur;
    logic [127:0] cookie_prev;
    logic [15:0]  epoch;
    logic         rot_busy;

    always #5 clk = ~clk;

    cookie_rotator_if #(.COOKIE_LEN(32)) chk_if ();

    cookie_rotator dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .time_stamp     (time_stamp),
        .cfg_period     (cfg_period),
        .cfg_period_vld (cfg_period_vld),
        .rot_req        (rot_req),
        .chk            (chk_if.slave),
        .cookie_cur     (cookie_cur),
        .cookie_prev    (cookie_prev),
        .epoch          (epoch),
        .rot_busy       (rot_busy)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mcur [4];
    logic [31:0] mprev [4];

    typedef struct {
        logic [3:0]  ch;
        logic [31:0] cookie;
        logic        hit;
        logic        stale;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mix(input logic [31:0] c,
                                        input logic [31:0] t,
                                        input int i);
        logic [31:0] s;
        s = c + {16'd0, t[31:16]};
        return (s ^ t) ^ 32'(i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mcur[i]  = BASE ^ 32'(i);
            mprev[i] = BASE ^ 32'(i);
        end
    endtask

    task automatic model_rot(input logic [31:0] t);
        for (int i = 0; i < 4; i++) begin
            mprev[i] = mcur[i];
            mcur[i]  = mix(mcur[i], t, i);
        end
    endtask

    task automatic check_cookies(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s cur%0d", tag, i),
                  96'(cookie_cur[i*32 +: 32]), 96'(mcur[i]));
            check($sformatf("%s prev%0d", tag, i),
                  96'(cookie_prev[i*32 +: 32]),
                  PREV ? 96'(mprev[i]) : 96'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_check(input string name, input logic [3:0] ch,
                            input logic [31:0] ck, input logic hit,
                            input logic stale);
        chk_if.chk_vld    = 1'b1;
        chk_if.chk_ch     = ch;
        chk_if.chk_cookie = ck;
        step();
        chk_if.chk_vld = 1'b0;
        check({name, " rsp_vld"}, 96'(chk_if.chk_rsp_vld), 96'd1);
        check({name, " hit"}, 96'(chk_if.chk_hit), 96'(hit));
        check({name, " stale"}, 96'(chk_if.chk_stale), 96'(stale));
    endtask

    task automatic single_rot(input logic [31:0] t);
        time_stamp = 96'(t);
        rot_req = 1'b1;
        step();
        rot_req = 1'b0;
        repeat (4) step();
        model_rot(t);
    endtask

    initial begin
        int k;
        int busy_n;
        int seen;
        logic pb;
        logic [15:0] e0;

        rst_n             = 1'b0;
        time_stamp        = '0;
        cfg_period        = '0;
        cfg_period_vld    = 1'b0;
        rot_req           = 1'b0;
        chk_if.chk_vld    = 1'b0;
        chk_if.chk_ch     = '0;
        chk_if.chk_cookie = '0;
        model_reset();
        #23;
        rst_n = 1'b1;
        step();

        check("rst cur0", 96'(cookie_cur[31:0]), 96'(32'hF1EC234D));
        check("rst cur1", 96'(cookie_cur[63:32]), 96'(32'hF1EC234C));
        check("rst cur3", 96'(cookie_cur[127:96]), 96'(32'hF1EC234E));
        check("rst epoch", 96'(epoch), 96'd0);
        check("rst busy", 96'(rot_busy), 96'd0);
        check("rst rsp_vld", 96'(chk_if.chk_rsp_vld), 96'd0);
        check_cookies("rst");

        time_stamp = 96'h0001_0000;
        rot_req = 1'b1;
        step();
        rot_req = 1'b0;
        busy_n = rot_busy ? 1 : 0;
        check("T busy", 96'(rot_busy), 96'd1);
        check("T cur0", 96'(cookie_cur[31:0]), 96'(32'hF1EC234D));
        step();
        busy_n += rot_busy ? 1 : 0;
        check("T+1 cur0", 96'(cookie_cur[31:0]), 96'(32'hF1ED234E));
        check("T+1 cur1", 96'(cookie_cur[63:32]), 96'(32'hF1EC234C));
        check("T+1 prev0", 96'(cookie_prev[31:0]),
              PREV ? 96'(32'hF1EC234D) : 96'd0);
        step();
        busy_n += rot_busy ? 1 : 0;
        check("T+2 cur1", 96'(cookie_cur[63:32]), 96'(32'hF1ED234C));
        step();
        busy_n += rot_busy ? 1 : 0;
        check("T+3 epoch", 96'(epoch), 96'd0);
        step();
        busy_n += rot_busy ? 1 : 0;
        check("T+4 epoch", 96'(epoch), 96'd1);
        check("T+4 busy", 96'(rot_busy), 96'd0);
        check("busy cycles", 96'(busy_n), 96'd4);
        check("T+4 cur2", 96'(cookie_cur[95:64]), 96'(32'hF1ED2352));
        check("T+4 cur3", 96'(cookie_cur[127:96]), 96'(32'hF1ED234C));
        model_rot(32'h0001_0000);
        check_cookies("rot1");

        vecs[0] = '{4'd0, 32'hF1EC234D, PREV, PREV};
        vecs[1] = '{4'd0, 32'hF1ED234E, 1'b1, 1'b0};
        vecs[2] = '{4'd0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3] = '{4'd5, 32'hF1ED234E, 1'b0, 1'b0};
        vecs[4] = '{4'd1, 32'hF1ED234C, 1'b1, 1'b0};
        vecs[5] = '{4'd3, 32'hF1EC234E, PREV, PREV};
        vecs[6] = '{4'd2, 32'hF1ED2352, 1'b1, 1'b0};
        vecs[7] = '{4'd15, 32'hF1EC234D, 1'b0, 1'b0};

        chk_if.chk_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_if.chk_ch     = vecs[i].ch;
            chk_if.chk_cookie = vecs[i].cookie;
            step();
            check($sformatf("vec%0d rsp_vld", i),
                  96'(chk_if.chk_rsp_vld), 96'd1);
            check($sformatf("vec%0d hit", i),
                  96'(chk_if.chk_hit), 96'(vecs[i].hit));
            check($sformatf("vec%0d stale", i),
                  96'(chk_if.chk_stale), 96'(vecs[i].stale));
        end
        chk_if.chk_vld = 1'b0;
        step();
        check("idle rsp_vld", 96'(chk_if.chk_rsp_vld), 96'd0);

        cfg_period = 32'd10;
        cfg_period_vld = 1'b1;
        step();
        cfg_period_vld = 1'b0;
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (rot_busy) begin
                k = i;
                break;
            end
        end
        check("period first rise", 96'(k), 96'd10);
        model_rot(32'h0001_0000);
        k = 0;
        pb = rot_busy;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (rot_busy && !pb) begin
                k = i;
                break;
            end
            pb = rot_busy;
        end
        check("period second rise", 96'(k), 96'd10);
        check("period epoch mid", 96'(epoch), 96'd2);
        model_rot(32'h0001_0000);
        repeat (4) step();
        check("period epoch end", 96'(epoch), 96'd3);
        check("period busy end", 96'(rot_busy), 96'd0);
        check_cookies("period");

        cfg_period = 32'd0;
        cfg_period_vld = 1'b1;
        step();
        cfg_period_vld = 1'b0;
        seen = 0;
        repeat (40) begin
            step();
            seen += rot_busy ? 1 : 0;
        end
        check("period0 busy", 96'(seen), 96'd0);
        check("period0 epoch", 96'(epoch), 96'd3);

        e0 = epoch;
        time_stamp = 96'h1234_5678;
        rot_req = 1'b1;
        step();
        rot_req = 1'b0;
        time_stamp = 96'h00AB_CDEF;
        busy_n = rot_busy ? 1 : 0;
        for (int j = 0; j < 3; j++) begin
            rot_req = 1'b1;
            step();
            rot_req = 1'b0;
            busy_n += rot_busy ? 1 : 0;
        end
        for (int j = 0; j < 20 && rot_busy; j++) begin
            step();
            busy_n += rot_busy ? 1 : 0;
        end
        check("pend busy cycles", 96'(busy_n), 96'd8);
        check("pend epoch", 96'(epoch), 96'(e0 + 16'd2));
        model_rot(32'h1234_5678);
        model_rot(32'h00AB_CDEF);
        check_cookies("pend");

        time_stamp = 96'h0001_0000;
        rot_req = 1'b1;
        step();
        rot_req = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cookies("midrst");
        check("midrst epoch", 96'(epoch), 96'd0);
        check("midrst busy", 96'(rot_busy), 96'd0);
        check("midrst hit", 96'(chk_if.chk_hit), 96'd0);
        #10;
        rst_n = 1'b1;
        step();
        check("post rst busy", 96'(rot_busy), 96'd0);
        single_rot(32'h0001_0000);
        check("post rst epoch", 96'(epoch), 96'd1);
        check_cookies("post rst");
        do_check("post stale", 4'd0, BASE, PREV, PREV);
        do_check("post cur", 4'd0, mcur[0], 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
